// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Multiplexed common-anode seven-segment display controller. One digit is
// driven at a time. The digit slot length is set by an internal clock-enable
// prescaler; no derived clock is used. Display data is snapshotted once per
// frame into shadow registers, so the picture never tears mid-scan.
// Per-digit blanking, decimal points, leading-zero blanking, hex or dash glyphs
// for values 10-15, and PWM brightness are supported.
//
// Parameters
//   N_DIGITS    : number of digits scanned (1..16)
//   REFRESH_DIV : clk cycles per digit slot (>= 2)
//   BRIGHT_W    : width of the brightness control
//   HEX_MODE    : 1 = A,b,C,d,E,F for nibbles 10-15; 0 = dash (segment g only)
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   digits_in   in   packed nibbles, nibble i = digit i (digit 0 = rightmost)
//   dp_in       in   decimal point request per digit
//   blank_in    in   force digit dark
//   lzb_en      in   leading-zero blanking enable
//   brightness  in   PWM duty control
//   anode_n     out  active-low digit enables (at most one low)
//   seg_n       out  active-low cathodes {g,f,e,d,c,b,a}
//   dp_n        out  active-low decimal point
//   frame_start out  one-cycle pulse, high in the first cycle the new shadow
//                    data is held
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4,
  parameter int HEX_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lzb_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [N_DIGITS-1:0]   anode_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_start
);

  // Index is at least one bit wide so a single-digit build still elaborates.
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE     = PRE_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE     = IDX_W'(1);
  localparam logic [BRIGHT_W-1:0] PWM_ONE     = BRIGHT_W'(1);
  localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = {BRIGHT_W{1'b1}};
  localparam logic [BRIGHT_W-1:0] BRIGHT_OFF  = {BRIGHT_W{1'b0}};
  localparam logic [6:0]          SEG_DARK    = 7'b1111111;

  // ---------------------------------------------------------------------------
  // Active-low glyph decode. Values 10-15 show letters or a dash depending on
  // HEX_MODE.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] decode_glyph(input logic [3:0] value);
    logic [6:0] glyph;
    case (value)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0011000;
      4'hA:    glyph = (HEX_MODE != 0) ? 7'b0001000 : 7'b0111111;
      4'hB:    glyph = (HEX_MODE != 0) ? 7'b0000011 : 7'b0111111;
      4'hC:    glyph = (HEX_MODE != 0) ? 7'b1000110 : 7'b0111111;
      4'hD:    glyph = (HEX_MODE != 0) ? 7'b0100001 : 7'b0111111;
      4'hE:    glyph = (HEX_MODE != 0) ? 7'b0000110 : 7'b0111111;
      4'hF:    glyph = (HEX_MODE != 0) ? 7'b0001110 : 7'b0111111;
      default: glyph = SEG_DARK;
    endcase
    return glyph;
  endfunction

  // Timing state
  logic [PRE_W-1:0]    prescaler_r;
  logic [IDX_W-1:0]    index_r;
  logic [BRIGHT_W-1:0] pwm_cnt_r;

  // Frame snapshot
  logic [4*N_DIGITS-1:0] shadow_digits_r;
  logic [N_DIGITS-1:0]   shadow_dp_r;
  logic [N_DIGITS-1:0]   shadow_blank_r;
  logic                  shadow_lzb_r;

  // Registered pin drivers
  logic [N_DIGITS-1:0] anode_n_r;
  logic [6:0]          seg_n_r;
  logic                dp_n_r;
  logic                frame_start_r;

  // Combinational helpers
  logic                tick_s;
  logic                frame_end_s;
  logic [PRE_W-1:0]    prescaler_nxt_s;
  logic [IDX_W-1:0]    index_nxt_s;
  logic [N_DIGITS-1:0] lzb_blank_s;
  logic                zero_run_s;
  logic [3:0]          cur_nibble_s;
  logic                cur_dp_s;
  logic                cur_blank_s;
  logic                cur_lzb_s;
  logic                pwm_on_s;
  logic                lit_s;
  logic [N_DIGITS-1:0] anode_n_s;
  logic [6:0]          seg_n_s;
  logic                dp_n_s;

  // Slot tick, prescaler wrap and digit-index advance.
  always_comb begin
    tick_s          = (prescaler_r == PRE_LAST);
    frame_end_s     = tick_s && (index_r == IDX_LAST);
    prescaler_nxt_s = prescaler_r + PRE_ONE;
    index_nxt_s     = index_r;
    if (tick_s) begin
      prescaler_nxt_s = {PRE_W{1'b0}};
      if (index_r == IDX_LAST) begin
        index_nxt_s = {IDX_W{1'b0}};
      end else begin
        index_nxt_s = index_r + IDX_ONE;
      end
    end else begin
      index_nxt_s = index_r;
    end
  end

  // Prescaler, digit index and free-running PWM counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_r <= {PRE_W{1'b0}};
      index_r     <= {IDX_W{1'b0}};
      pwm_cnt_r   <= {BRIGHT_W{1'b0}};
    end else begin
      prescaler_r <= prescaler_nxt_s;
      index_r     <= index_nxt_s;
      pwm_cnt_r   <= pwm_cnt_r + PWM_ONE;
    end
  end

  // Frame snapshot: inputs are captured only at the last slot's tick, so
  // changes mid-frame never reach the pins. Blank-all after reset keeps the
  // display dark until the first real snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_digits_r <= {(4*N_DIGITS){1'b0}};
      shadow_dp_r     <= {N_DIGITS{1'b0}};
      shadow_blank_r  <= {N_DIGITS{1'b1}};
      shadow_lzb_r    <= 1'b0;
    end else if (frame_end_s) begin
      shadow_digits_r <= digits_in;
      shadow_dp_r     <= dp_in;
      shadow_blank_r  <= blank_in;
      shadow_lzb_r    <= lzb_en;
    end else begin
      shadow_digits_r <= shadow_digits_r;
      shadow_dp_r     <= shadow_dp_r;
      shadow_blank_r  <= shadow_blank_r;
      shadow_lzb_r    <= shadow_lzb_r;
    end
  end

  // Leading-zero mask: walk from the most significant digit down, keeping a
  // run flag that stays set while digits are zero with no decimal point.
  // Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    zero_run_s  = 1'b1;
    lzb_blank_s = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (shadow_digits_r[4*i +: 4] == 4'h0) & ~shadow_dp_r[i];
      if ((i != 0) && shadow_lzb_r) begin
        lzb_blank_s[i] = zero_run_s;
      end else begin
        lzb_blank_s[i] = 1'b0;
      end
    end
  end

  // And-or mux selecting the shadow data of the digit currently scanned.
  always_comb begin
    cur_nibble_s = 4'h0;
    cur_dp_s     = 1'b0;
    cur_blank_s  = 1'b0;
    cur_lzb_s    = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      cur_nibble_s = cur_nibble_s | (shadow_digits_r[4*i +: 4] & {4{index_r == IDX_W'(i)}});
      cur_dp_s     = cur_dp_s    | (shadow_dp_r[i]    & (index_r == IDX_W'(i)));
      cur_blank_s  = cur_blank_s | (shadow_blank_r[i] & (index_r == IDX_W'(i)));
      cur_lzb_s    = cur_lzb_s   | (lzb_blank_s[i]    & (index_r == IDX_W'(i)));
    end
  end

  // PWM gate: full scale forces on (the compare alone would drop one count),
  // zero forces off, otherwise on while the counter is below the setting.
  always_comb begin
    if (brightness == BRIGHT_FULL) begin
      pwm_on_s = 1'b1;
    end else if (brightness == BRIGHT_OFF) begin
      pwm_on_s = 1'b0;
    end else begin
      pwm_on_s = (pwm_cnt_r < brightness);
    end
  end

  // Pin values for the current slot; a dark digit drives every line high.
  always_comb begin
    lit_s     = ~cur_blank_s & ~cur_lzb_s & pwm_on_s;
    anode_n_s = {N_DIGITS{1'b1}};
    for (int i = 0; i < N_DIGITS; i++) begin
      anode_n_s[i] = ~(lit_s & (index_r == IDX_W'(i)));
    end
    if (lit_s) begin
      seg_n_s = decode_glyph(cur_nibble_s);
      dp_n_s  = ~cur_dp_s;
    end else begin
      seg_n_s = SEG_DARK;
      dp_n_s  = 1'b1;
    end
  end

  // Output registers: one-cycle latency to the pins, glitch-free drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_n_r     <= {N_DIGITS{1'b1}};
      seg_n_r       <= SEG_DARK;
      dp_n_r        <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      anode_n_r     <= anode_n_s;
      seg_n_r       <= seg_n_s;
      dp_n_r        <= dp_n_s;
      frame_start_r <= frame_end_s;
    end
  end

  assign anode_n     = anode_n_r;
  assign seg_n       = seg_n_r;
  assign dp_n        = dp_n_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//
// Scoreboard bench. The stimulus process drives inputs on the falling edge and
// pushes the pin values a reference model predicts for the following rising
// edge. A monitor pops one entry per cycle just after each rising edge and
// compares. Two DUTs share the inputs: one with hex glyphs, one with dashes.
// The model works from elapsed cycles since reset (slot = t / DIV, pwm = t % 4)
// and a frame snapshot taken every N*DIV cycles.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BW    = 2;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_h0;
    logic       dp;
    logic       fs;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   digits_in = 16'h0000;
  logic [3:0]    dp_in = 4'h0;
  logic [3:0]    blank_in = 4'h0;
  logic          lzb_en = 1'b0;
  logic [BW-1:0] brightness = 2'd3;

  logic [3:0] anode_n, anode_n_h0;
  logic [6:0] seg_n, seg_n_h0;
  logic       dp_n, dp_n_h0, frame_start, frame_start_h0;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   started = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Model state
  int          t_m = 0;
  logic [15:0] sh_dig = 16'h0000;
  logic [3:0]  sh_dp = 4'h0;
  logic [3:0]  sh_blank = 4'hF;
  bit          sh_lzb = 1'b0;

  seven_seg_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV), .BRIGHT_W(BW), .HEX_MODE(1)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lzb_en(lzb_en), .brightness(brightness),
    .anode_n(anode_n), .seg_n(seg_n), .dp_n(dp_n), .frame_start(frame_start)
  );

  seven_seg_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV), .BRIGHT_W(BW), .HEX_MODE(0)) dut_h0 (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lzb_en(lzb_en), .brightness(brightness),
    .anode_n(anode_n_h0), .seg_n(seg_n_h0), .dp_n(dp_n_h0), .frame_start(frame_start_h0)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  // Apply one cycle of inputs and queue the prediction for the next rising edge.
  task automatic drive(input bit r, input logic [15:0] d, input logic [3:0] dpv,
                       input logic [3:0] bl, input bit lz, input logic [BW-1:0] br);
    exp_t e;
    int   idx;
    int   pwm;
    int   nib;
    bit   lzb_dark;
    bit   lit;
    @(negedge clk);
    reset      = r;
    digits_in  = d;
    dp_in      = dpv;
    blank_in   = bl;
    lzb_en     = lz;
    brightness = br;
    e.an = 4'hF; e.seg = 7'h7F; e.seg_h0 = 7'h7F; e.dp = 1'b1; e.fs = 1'b0;
    if (r) begin
      t_m = 0; sh_dig = 16'h0000; sh_dp = 4'h0; sh_blank = 4'hF; sh_lzb = 1'b0;
    end else begin
      idx = (t_m / DIV) % N;
      pwm = t_m % (1 << BW);
      lzb_dark = 1'b0;
      if (sh_lzb && idx != 0) begin
        lzb_dark = 1'b1;
        for (int j = idx; j < N; j++) begin
          if (sh_dig[4*j +: 4] != 4'h0 || sh_dp[j]) lzb_dark = 1'b0;
        end
      end
      lit = !sh_blank[idx] && !lzb_dark &&
            ((int'(br) == (1 << BW) - 1) || (br != 0 && pwm < int'(br)));
      if (lit) begin
        nib       = int'(sh_dig[4*idx +: 4]);
        e.an[idx] = 1'b0;
        e.seg     = GLYPH[nib];
        e.seg_h0  = (nib >= 10) ? 7'b0111111 : GLYPH[nib];
        e.dp      = !sh_dp[idx];
      end
      e.fs = ((t_m % FRAME) == FRAME - 1);
      if (e.fs) begin
        sh_dig = d; sh_dp = dpv; sh_blank = bl; sh_lzb = lz;
      end
      t_m++;
    end
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  task automatic run(input int n, input logic [15:0] d, input logic [3:0] dpv,
                     input logic [3:0] bl, input bit lz, input logic [BW-1:0] br);
    for (int k = 0; k < n; k++) drive(1'b0, d, dpv, bl, lz, br);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      v[4*k +: 4] = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 0));
    end
    return v;
  endfunction

  // Monitor: one scoreboard entry per cycle, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (started) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty at %0t: got no entry, required one", $time);
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if ({anode_n, seg_n, dp_n, frame_start} !== {mon_e.an, mon_e.seg, mon_e.dp, mon_e.fs}) begin
          bad++;
          $display("FAIL pins_hex at %0t: got an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
                   $time, anode_n, seg_n, dp_n, frame_start, mon_e.an, mon_e.seg, mon_e.dp, mon_e.fs);
        end
        total++;
        if ({anode_n_h0, seg_n_h0, dp_n_h0, frame_start_h0} !== {mon_e.an, mon_e.seg_h0, mon_e.dp, mon_e.fs}) begin
          bad++;
          $display("FAIL pins_dash at %0t: got an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
                   $time, anode_n_h0, seg_n_h0, dp_n_h0, frame_start_h0, mon_e.an, mon_e.seg_h0, mon_e.dp, mon_e.fs);
        end
        total++;
        if ($countones(~anode_n) > 1) begin
          bad++;
          $display("FAIL one_anode at %0t: got an=%b, required at most one low bit", $time, anode_n);
        end
      end
    end
  end

  // Stimulus: directed scenarios from the plan, then random traffic.
  initial begin
    logic [15:0]   rd;
    logic [3:0]    rdp, rbl;
    bit            rlz, rr;
    logic [BW-1:0] rbr;

    for (int k = 0; k < 3; k++) drive(1'b1, 16'h4321, 4'h0, 4'h0, 1'b0, 2'd3);
    run(18, 16'h4321, 4'h0, 4'h0, 1'b0, 2'd3);   // dark frame, then 4,3,2,1
    run(40, 16'h9999, 4'h0, 4'h0, 1'b0, 2'd3);   // change mid-frame
    drive(1'b1, 16'h9999, 4'h0, 4'h0, 1'b0, 2'd3); // reset mid-slot
    run(36, 16'h0050, 4'h0, 4'h0, 1'b1, 2'd3);
    run(36, 16'h0000, 4'h0, 4'h0, 1'b1, 2'd3);
    run(36, 16'h0050, 4'h8, 4'h0, 1'b1, 2'd3);
    run(36, 16'hABCD, 4'h0, 4'h0, 1'b0, 2'd3);
    run(36, 16'hABCD, 4'h0, 4'h2, 1'b0, 2'd3);
    run(36, 16'h4321, 4'h0, 4'h0, 1'b0, 2'd1);
    run(36, 16'h4321, 4'h0, 4'h0, 1'b0, 2'd0);
    run(36, 16'h4321, 4'h5, 4'h0, 1'b0, 2'd2);
    run(36, 16'h4321, 4'h0, 4'h0, 1'b0, 2'd3);

    rd = 16'h1234; rdp = 4'h0; rbl = 4'h0; rlz = 1'b1; rbr = 2'd3;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7, 0) == 0)  rd  = rand_digits();
      if ($urandom_range(15, 0) == 0) rdp = 4'($urandom_range(15, 0));
      if ($urandom_range(15, 0) == 0) rbl = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 0));
      if ($urandom_range(15, 0) == 0) rlz = 1'($urandom_range(1, 0));
      if ($urandom_range(15, 0) == 0) rbr = BW'($urandom_range(3, 0));
      rr = ($urandom_range(199, 0) == 0);
      drive(rr, rd, rdp, rbl, rlz, rbr);
    end

    @(posedge clk);
    #2;
    started = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

endmodule
